// File: rtl/led_pulse_stretcher.sv
// Stretches one-cycle trig events into human-visible pulses with a minimum gap
// between them; events arriving while busy are queued up to MAX_PENDING.
module led_pulse_stretcher #(
  parameter int TICK_DIV    = 500000,
  parameter int ON_TICKS    = 20,
  parameter int OFF_TICKS   = 10,
  parameter int MAX_PENDING = 15
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       trig,
  output logic       out,
  output logic       busy,
  output logic [3:0] pending,
  output logic       overflow
);

  localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int MAXT = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int TW   = (MAXT > 1) ? $clog2(MAXT) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0] ON_LAST    = TW'(ON_TICKS - 1);
  localparam logic [TW-1:0] OFF_LAST   = TW'(OFF_TICKS - 1);
  localparam logic [3:0]    PEND_MAX   = 4'(MAX_PENDING);

  typedef enum logic [1:0] {IDLE, ON, GAP} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] presc;
  logic [TW-1:0] tcnt;
  logic          tick, on_done, gap_done;
  logic          launch, take_q, take_trig, accept, entering;
  logic [3:0]    pend_nxt;
  logic          ovf_nxt;

  assign tick     = (presc == PRESC_LAST);
  assign on_done  = (state == ON)  && tick && (tcnt == ON_LAST);
  assign gap_done = (state == GAP) && tick && (tcnt == OFF_LAST);

  // A new pulse starts from IDLE or at the end of a gap; the queue is served
  // first, and a trig only launches directly when nothing is queued.
  assign launch    = ((state == IDLE) || gap_done) && (trig || (pending != 4'd0));
  assign take_q    = launch && (pending != 4'd0);
  assign take_trig = launch && (pending == 4'd0);
  assign accept    = trig && !take_trig;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (launch)   state_nxt = ON;
      ON:      if (on_done)  state_nxt = GAP;
      GAP:     if (gap_done) state_nxt = launch ? ON : IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  // Every transition into ON or GAP restarts the tick timing from zero.
  assign entering = (state_nxt != state) && (state_nxt != IDLE);

  always_comb begin
    pend_nxt = pending;
    ovf_nxt  = 1'b0;
    if (accept && !take_q) begin
      if (pending < PEND_MAX) pend_nxt = pending + 4'd1;
      else                    ovf_nxt  = 1'b1;
    end else if (take_q && !accept) begin
      pend_nxt = pending - 4'd1;
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      presc <= '0;
      tcnt  <= '0;
    end else if (entering || (state_nxt == IDLE)) begin
      presc <= '0;
      tcnt  <= '0;
    end else if (tick) begin
      presc <= '0;
      tcnt  <= tcnt + TW'(1);
    end else begin
      presc <= presc + PW'(1);
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      out      <= 1'b0;
      busy     <= 1'b0;
      pending  <= 4'd0;
      overflow <= 1'b0;
    end else begin
      out      <= (state_nxt == ON);
      busy     <= (state_nxt != IDLE);
      pending  <= pend_nxt;
      overflow <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_led_pulse_stretcher.sv
// Directed bench for led_pulse_stretcher with TICK_DIV=4, ON_TICKS=3, OFF_TICKS=2
// (12-cycle pulses, 8-cycle gaps).
module tb_led_pulse_stretcher;

  logic       clk_in, rst, trig;
  logic       out, busy, overflow;
  logic [3:0] pending;
  logic       clk_en;

  int checks = 0;
  int errors = 0;

  led_pulse_stretcher #(
    .TICK_DIV(4), .ON_TICKS(3), .OFF_TICKS(2), .MAX_PENDING(15)
  ) dut (
    .clk_in(clk_in), .rst(rst), .trig(trig),
    .out(out), .busy(busy), .pending(pending), .overflow(overflow)
  );

  initial begin
    clk_in = 1'b0;
    wait (clk_en);
    forever #5 clk_in = ~clk_in;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    int pulses, ovfs, highs, maxp, n;
    logic prev;
    clk_en = 1'b0;
    rst    = 1'b0;
    trig   = 1'b0;

    // reset with no clock running
    #1 rst = 1'b1;
    #1;
    chk("rst_out", out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pend", pending, 0);
    chk("rst_ovf", overflow, 0);
    clk_en = 1'b1;
    step(); step();
    @(negedge clk_in) rst = 1'b0;
    step();
    chk("idle_busy", busy, 0);

    // single event: ON k=0..11, GAP k=12..19, IDLE from k=20
    for (int k = 0; k <= 21; k++) begin
      trig = (k == 0);
      step();
      chk($sformatf("single_out_k%0d", k), out, (k < 12) ? 1 : 0);
      chk($sformatf("single_busy_k%0d", k), busy, (k < 20) ? 1 : 0);
    end
    trig = 1'b0;
    step(); step();

    // back-to-back: three trigs, three pulses, queue drains 2->1->0
    for (int k = 0; k <= 61; k++) begin
      trig = (k < 3);
      step();
      chk($sformatf("b2b_out_k%0d", k), out, (k < 60 && (k % 20) < 12) ? 1 : 0);
      chk($sformatf("b2b_busy_k%0d", k), busy, (k < 60) ? 1 : 0);
      chk($sformatf("b2b_pend_k%0d", k), pending,
          (k == 0) ? 0 : (k == 1) ? 1 : (k < 20) ? 2 : (k < 40) ? 1 : 0);
    end
    trig = 1'b0;
    step();

    // trig in the last GAP cycle with empty queue relaunches without IDLE
    for (int k = 0; k <= 40; k++) begin
      trig = (k == 0) || (k == 20);
      step();
      chk($sformatf("gapb_out_k%0d", k), out, (k < 40 && (k % 20) < 12) ? 1 : 0);
      chk($sformatf("gapb_busy_k%0d", k), busy, (k < 40) ? 1 : 0);
      chk($sformatf("gapb_pend_k%0d", k), pending, 0);
    end
    trig = 1'b0;
    step();

    // saturation: 17 consecutive trigs -> 15 queued, one drop, 16 pulses
    pulses = 0; ovfs = 0; maxp = 0; prev = 1'b0;
    for (int k = 0; k <= 16; k++) begin
      trig = 1'b1;
      step();
      chk($sformatf("sat_pend_k%0d", k), pending, (k > 15) ? 15 : k);
      chk($sformatf("sat_ovf_k%0d", k), overflow, (k == 16) ? 1 : 0);
      if (out && !prev) pulses++;
      if (overflow) ovfs++;
      if (int'(pending) > maxp) maxp = int'(pending);
      prev = out;
    end
    trig = 1'b0;
    n = 0;
    while (busy && n < 1000) begin
      step();
      n++;
      if (out && !prev) pulses++;
      if (overflow) ovfs++;
      if (int'(pending) > maxp) maxp = int'(pending);
      prev = out;
    end
    chk("sat_drained", busy, 0);
    chk("sat_pulses", pulses, 16);
    chk("sat_ovf_count", ovfs, 1);
    chk("sat_max_pend", maxp, 15);
    chk("sat_end_pend", pending, 0);
    step();

    // reset mid-ON with 5 queued events
    for (int k = 0; k <= 5; k++) begin
      trig = 1'b1;
      step();
    end
    trig = 1'b0;
    chk("mid_pend_before", pending, 5);
    chk("mid_out_before", out, 1);
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_out", out, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_pend", pending, 0);
    chk("mid_rst_ovf", overflow, 0);
    @(negedge clk_in) rst = 1'b0;
    highs = 0;
    for (int k = 0; k < 100; k++) begin
      step();
      if (out || busy) highs++;
    end
    chk("mid_no_resume", highs, 0);

    // trig on the first edge after reset release is accepted
    @(negedge clk_in) rst = 1'b1;
    @(negedge clk_in) rst = 1'b0;
    trig = 1'b1;
    step();
    trig = 1'b0;
    chk("post_rst_out", out, 1);
    chk("post_rst_busy", busy, 1);
    chk("post_rst_pend", pending, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
